seg7_multi_display: RTL and testbench
=====================================

Name: seg7_multi_display

Overview:
- Parametrised N-digit seven-segment display controller for the DE10-Lite HEX bank; successor to the fixed dual-digit blank/test decoder.
- Holds a display word loaded through a valid/ready handshake, double-buffered and applied on frame ticks.
- Supports static, blink, scroll and free-running count modes with blank/test overrides.
- Sits between switch/processor logic and the HEX0..HEX(N-1) pins.

Parameters:
- NUM_DIGITS, 6, number of digits driven; display word width DATA_W = 4*NUM_DIGITS (derived localparam).
- TICK_DIV, 25_000_000, clk cycles per frame tick (scroll/blink/count step); must be >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- mode  input  2  display mode: 00 STATIC, 01 BLINK, 10 SCROLL, 11 COUNT
- blank  input  1  force all segments off
- test  input  1  force all segments on
- load_valid  input  1  new display word offered
- load_data  input  DATA_W  new word; nibble k drives digit k (digit 0 = rightmost, LSBs)
- load_ready  output  1  controller can accept a word
- segments  output  7*NUM_DIGITS  active-low segments; digit k at [7k+6:7k], bit order g..a
- frame_tick  output  1  one-cycle pulse per frame tick

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: tick counter 0, disp 0, shadow 0, pending 0, offset 0, blink_on 1, prev_mode 00, frame_tick 0, load_ready 1, segments all 7'h7F (blank).
- Tick counter: counts 0..TICK_DIV-1 and wraps. The internal tick is asserted in the cycle count == TICK_DIV-1. frame_tick is the registered tick, 1 cycle later.
- Handshake:
  - load_ready = !pending (combinational from the register).
  - On load_valid && load_ready: shadow <= load_data, pending <= 1.
  - No further loads are accepted until the shadow is applied.
- Apply: on tick with pending = 1:
  - disp <= shadow, pending <= 0, offset <= 0, blink_on <= 1.
  - Apply has priority over COUNT increment, scroll advance and blink toggle in that tick.
- Simultaneous load and tick (pending = 0): the word is captured into shadow and applied on the next tick, never the same tick.
- Mode behaviour on a tick without pending:
  - STATIC: no change.
  - BLINK: blink_on toggles.
  - SCROLL: offset <= (offset+1) mod NUM_DIGITS; wraps from NUM_DIGITS-1 to 0.
  - COUNT: disp <= disp + 1 mod 2^DATA_W; all-F wraps to 0.
- Mode change: when mode != prev_mode, offset <= 0 and blink_on <= 1 in that cycle. Tick actions for that cycle are suppressed, except apply. prev_mode updates every cycle.
- Digit source:
  - Digit k shows nibble (k + offset) mod NUM_DIGITS of disp in SCROLL mode.
  - Digit k shows nibble k of disp in all other modes.
- Decode: hex 0-F, active-low; 0 = 7'h40, 8 = 7'h00, F = 7'h0E.
- Output priority: blank (7'h7F) > test (7'h00) > (BLINK && !blink_on → 7'h7F) > decoded digit.
- Output timing: segments registered, 1-cycle latency from any input/state change.
- Reset mid-operation: pending load discarded, display blanks on the next cycle, tick phase restarts at 0.

Decomposition:
- Package seg7_pkg:
  - mode_t enum (MODE_STATIC, MODE_BLINK, MODE_SCROLL, MODE_COUNT).
  - SEG_BLANK = 7'h7F, SEG_ALL_ON = 7'h00.
  - Function hex_to_seg(logic [3:0]) returning logic [6:0].
- Sub-module hex_seg7: combinational single-digit decoder wrapping hex_to_seg, instantiated NUM_DIGITS times via generate.
- Top-level board wrapper ties mode/blank/test/load to SW/KEY and segments to HEX0..HEX5.

Test Plan (bench uses NUM_DIGITS = 6, TICK_DIV = 4):
- Reset, then load 24'h123456 in STATIC mode.
  - load_ready drops the next cycle.
  - After the next tick + 1 cycle, HEX0..HEX5 = 6,5,4,3,2,1 (7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79).
  - load_ready returns to 1.
- Hold load_valid with 24'hABCDEF while pending.
  - Second word is not accepted until after the apply tick.
  - load_ready = 0 for the whole interval, and the first word is displayed first.
- SCROLL with 24'h012345:
  - After 1 tick, digit0 shows 4.
  - After 6 ticks, offset wraps to 0 and digit0 shows 5 again.
  - A mode change mid-scroll resets offset to 0.
- COUNT mode loaded with 24'hFFFFFE: after 2 ticks disp = 24'h000000, all digits 7'h40.
- BLINK: segments alternate between the decoded value and 7'h7F each tick.
  - blank = 1 forces 7'h7F and test = 1 forces 7'h00; blank wins when both are set.
  - Each override takes effect with 1-cycle latency.
- Assert reset while pending = 1 and mid-count.
  - The next cycle has segments all 7'h7F, load_ready = 1, frame_tick = 0.
  - The first frame_tick arrives exactly TICK_DIV + 1 cycles after reset deasserts.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the multi-digit seven-segment controller.
// Segment encoding is active-low, bit order g..a.
package seg7_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_SCROLL = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_t;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_ALL_ON = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_seg7.sv
// Combinational single-digit hex decoder; active-low segments, bit order g..a.
module hex_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg7_multi_display.sv
// N-digit seven-segment controller: handshake-loaded, double-buffered display word applied on
// frame ticks, with static/blink/scroll/count modes and blank/test overrides.
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned TICK_DIV   = 25_000_000,
    localparam int unsigned DATA_W    = 4 * NUM_DIGITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic                    blank,
    input  logic                    test,
    input  logic                    load_valid,
    input  logic [DATA_W-1:0]       load_data,
    output logic                    load_ready,
    output logic [7*NUM_DIGITS-1:0] segments,
    output logic                    frame_tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned OFF_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tick;
    logic                    frame_tick_q;
    logic [DATA_W-1:0]       disp_q, disp_d;
    logic [DATA_W-1:0]       shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic [OFF_W-1:0]        offset_q, offset_d;
    logic                    blink_on_q, blink_on_d;
    mode_t                   prev_mode_q;
    mode_t                   cur_mode;
    logic                    mode_changed;
    logic [DATA_W-1:0]       src_word;
    logic [6:0]              dec_seg [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] segments_q, segments_d;

    assign cur_mode     = mode_t'(mode);
    assign mode_changed = (cur_mode != prev_mode_q);

    assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    always_comb begin
        disp_d     = disp_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        offset_d   = offset_q;
        blink_on_d = blink_on_q;

        // Only accepted while empty, so a capture can never collide with an apply.
        if (load_valid && !pending_q) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end

        if (tick && pending_q) begin
            disp_d     = shadow_q;
            pending_d  = 1'b0;
            offset_d   = '0;
            blink_on_d = 1'b1;
        end else if (mode_changed) begin
            offset_d   = '0;
            blink_on_d = 1'b1;
        end else if (tick) begin
            unique case (cur_mode)
                MODE_STATIC: ;
                MODE_BLINK:  blink_on_d = !blink_on_q;
                MODE_SCROLL: offset_d = (offset_q == OFF_W'(NUM_DIGITS - 1)) ?
                                        '0 : offset_q + OFF_W'(1);
                MODE_COUNT:  disp_d = disp_q + DATA_W'(1);
            endcase
        end
    end

    // Rotating the doubled word right by offset nibbles puts nibble (k+offset) mod N at digit k.
    always_comb begin
        src_word = disp_q;
        if (cur_mode == MODE_SCROLL) begin
            src_word = DATA_W'({disp_q, disp_q} >> {offset_q, 2'b00});
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        hex_seg7 u_hex_seg7 (
            .hex (src_word[4*k +: 4]),
            .seg (dec_seg[k])
        );
    end

    always_comb begin
        segments_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (blank) begin
                segments_d[7*k +: 7] = SEG_BLANK;
            end else if (test) begin
                segments_d[7*k +: 7] = SEG_ALL_ON;
            end else if (cur_mode == MODE_BLINK && !blink_on_q) begin
                segments_d[7*k +: 7] = SEG_BLANK;
            end else begin
                segments_d[7*k +: 7] = dec_seg[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            frame_tick_q <= 1'b0;
            disp_q       <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            offset_q     <= '0;
            blink_on_q   <= 1'b1;
            prev_mode_q  <= MODE_STATIC;
            segments_q   <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            cnt_q        <= cnt_d;
            frame_tick_q <= tick;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            offset_q     <= offset_d;
            blink_on_q   <= blink_on_d;
            prev_mode_q  <= cur_mode;
            segments_q   <= segments_d;
        end
    end

    assign load_ready = !pending_q;
    assign frame_tick = frame_tick_q;
    assign segments   = segments_q;

endmodule

// File: tb/tb_seg7_multi_display.sv
// Scenario bench for seg7_multi_display (6 digits, 4-cycle frame); expected segment words are
// queued when stimulus is driven and popped when the DUT output is due.
module tb_seg7_multi_display;

    localparam int unsigned ND = 6;
    localparam int unsigned TD = 4;
    localparam int unsigned DW = 4 * ND;
    localparam int unsigned SW = 7 * ND;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic          blank;
    logic          test;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic [SW-1:0] segments;
    logic          frame_tick;

    int n_run  = 0;
    int n_fail = 0;

    logic [SW-1:0] exp_q[$];
    string         name_q[$];
    logic [SW-1:0] exp_w;
    string         exp_n;

    seg7_multi_display #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .blank      (blank),
        .test       (test),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .segments   (segments),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [SW-1:0] ref_word(input logic [DW-1:0] w, input int off);
        logic [SW-1:0] r;
        r = '0;
        for (int k = 0; k < ND; k++) r[7*k +: 7] = ref_seg(w[4*((k + off) % ND) +: 4]);
        return r;
    endfunction

    function automatic logic [SW-1:0] fill(input logic [6:0] s);
        return {ND{s}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * TD && !ok; i++) begin
            step();
            if (frame_tick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit early;
        reset = 1'b1; mode = 2'b00; blank = 1'b0; test = 1'b0;
        load_valid = 1'b0; load_data = '0;
        step(); step();
        reset = 1'b0;
        n_run++;
        if (segments !== fill(7'h7F)) begin
            n_fail++; $display("FAIL reset_segments: got %h want %h", segments, fill(7'h7F));
        end
        n_run++;
        if (load_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", load_ready);
        end
        n_run++;
        if (frame_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick);
        end
        // The current cycle is cycle 1 out of reset; frame_tick must first appear in TD+1.
        early = 1'b0;
        for (int c = 2; c <= TD; c++) begin
            step();
            if (frame_tick !== 1'b0) early = 1'b1;
        end
        step();
        n_run++;
        if (early || frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_tick: early=%b tick=%b want early=0 tick=1",
                     early, frame_tick);
        end
    endtask

    task automatic test_static();
        bit ok;
        mode = 2'b00;
        load_data = 24'h123456; load_valid = 1'b1;
        exp_q.push_back({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        name_q.push_back("static_123456");
        step();
        load_valid = 1'b0;
        n_run++;
        if (load_ready !== 1'b0) begin
            n_fail++; $display("FAIL static_ready_drop: got %b want 0", load_ready);
        end
        wait_frame(ok);
        n_run++;
        if (!ok) begin
            n_fail++; $display("FAIL static_tick_timeout: got no frame_tick want one");
        end
        n_run++;
        if (load_ready !== 1'b1) begin
            n_fail++; $display("FAIL static_ready_back: got %b want 1", load_ready);
        end
        step();
        exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
        n_run++;
        if (segments !== exp_w) begin
            n_fail++; $display("FAIL %s: got %h want %h", exp_n, segments, exp_w);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, bad;
        load_data = 24'h13579B; load_valid = 1'b1;
        exp_q.push_back(ref_word(24'h13579B, 0)); name_q.push_back("hold_first_word");
        exp_q.push_back(ref_word(24'hABCDEF, 0)); name_q.push_back("hold_second_word");
        step();
        load_data = 24'hABCDEF;
        ok = 1'b0; bad = 1'b0;
        for (int i = 0; i < 3 * TD && !ok; i++) begin
            if (load_ready !== 1'b0) bad = 1'b1;
            step();
            if (frame_tick === 1'b1) ok = 1'b1;
        end
        n_run++;
        if (!ok || bad) begin
            n_fail++; $display("FAIL hold_ready_low: tick=%b ready_seen_high=%b want 1/0", ok, bad);
        end
        n_run++;
        if (load_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_ready_after_apply: got %b want 1", load_ready);
        end
        step();
        exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
        n_run++;
        if (segments !== exp_w) begin
            n_fail++; $display("FAIL %s: got %h want %h", exp_n, segments, exp_w);
        end
        n_run++;
        if (load_ready !== 1'b0) begin
            n_fail++; $display("FAIL hold_second_taken: got %b want 0", load_ready);
        end
        load_valid = 1'b0;
        wait_frame(ok);
        step();
        exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
        n_run++;
        if (!ok || segments !== exp_w) begin
            n_fail++; $display("FAIL %s: tick=%b got %h want %h", exp_n, ok, segments, exp_w);
        end
    endtask

    task automatic test_scroll();
        bit ok;
        mode = 2'b10;
        load_data = 24'h012345; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int t = 0; t <= 8; t++) begin
            exp_q.push_back(ref_word(24'h012345, t % ND));
            name_q.push_back($sformatf("scroll_offset_%0d", t % ND));
            wait_frame(ok);
            step();
            exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
            n_run++;
            if (!ok || segments !== exp_w) begin
                n_fail++; $display("FAIL %s: tick=%b got %h want %h", exp_n, ok, segments, exp_w);
            end
        end
        // Offset is 2 here; a detour through STATIC must bring it back to 0.
        mode = 2'b00;
        step();
        mode = 2'b10;
        exp_q.push_back(ref_word(24'h012345, 0)); name_q.push_back("scroll_mode_change");
        step();
        exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
        n_run++;
        if (segments !== exp_w) begin
            n_fail++; $display("FAIL %s: got %h want %h", exp_n, segments, exp_w);
        end
    endtask

    task automatic test_count();
        bit ok;
        mode = 2'b11;
        load_data = 24'hFFFFFE; load_valid = 1'b1;
        exp_q.push_back(ref_word(24'hFFFFFE, 0)); name_q.push_back("count_fffffe");
        exp_q.push_back(ref_word(24'hFFFFFF, 0)); name_q.push_back("count_ffffff");
        exp_q.push_back(fill(7'h40));             name_q.push_back("count_wrap_zero");
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_frame(ok);
            step();
            exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
            n_run++;
            if (!ok || segments !== exp_w) begin
                n_fail++; $display("FAIL %s: tick=%b got %h want %h", exp_n, ok, segments, exp_w);
            end
        end
    endtask

    task automatic test_blink_overrides();
        bit ok;
        mode = 2'b01;
        load_data = 24'h987654; load_valid = 1'b1;
        exp_q.push_back(ref_word(24'h987654, 0)); name_q.push_back("blink_on");
        exp_q.push_back(fill(7'h7F));             name_q.push_back("blink_off");
        exp_q.push_back(ref_word(24'h987654, 0)); name_q.push_back("blink_on_again");
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_frame(ok);
            step();
            exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
            n_run++;
            if (!ok || segments !== exp_w) begin
                n_fail++; $display("FAIL %s: tick=%b got %h want %h", exp_n, ok, segments, exp_w);
            end
        end
        mode = 2'b00;
        step();
        blank = 1'b1;
        n_run++;
        if (segments !== ref_word(24'h987654, 0)) begin
            n_fail++; $display("FAIL blank_latency: got %h want %h",
                               segments, ref_word(24'h987654, 0));
        end
        exp_q.push_back(fill(7'h7F)); name_q.push_back("blank_forces_off");
        step();
        exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
        n_run++;
        if (segments !== exp_w) begin
            n_fail++; $display("FAIL %s: got %h want %h", exp_n, segments, exp_w);
        end
        test = 1'b1;
        exp_q.push_back(fill(7'h7F)); name_q.push_back("blank_beats_test");
        step();
        exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
        n_run++;
        if (segments !== exp_w) begin
            n_fail++; $display("FAIL %s: got %h want %h", exp_n, segments, exp_w);
        end
        blank = 1'b0;
        exp_q.push_back(fill(7'h00)); name_q.push_back("test_forces_on");
        step();
        exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
        n_run++;
        if (segments !== exp_w) begin
            n_fail++; $display("FAIL %s: got %h want %h", exp_n, segments, exp_w);
        end
        test = 1'b0;
        n_run++;
        if (segments !== fill(7'h00)) begin
            n_fail++; $display("FAIL test_latency: got %h want %h", segments, fill(7'h00));
        end
        exp_q.push_back(ref_word(24'h987654, 0)); name_q.push_back("override_release");
        step();
        exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
        n_run++;
        if (segments !== exp_w) begin
            n_fail++; $display("FAIL %s: got %h want %h", exp_n, segments, exp_w);
        end
    endtask

    task automatic test_reset_mid();
        bit early;
        mode = 2'b11;
        load_data = 24'h555555; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        n_run++;
        if (load_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_pending_set: got %b want 0", load_ready);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_run++;
        if (segments !== fill(7'h7F) || load_ready !== 1'b1 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state: seg=%h ready=%b tick=%b want %h/1/0",
                     segments, load_ready, frame_tick, fill(7'h7F));
        end
        early = 1'b0;
        for (int c = 2; c <= TD; c++) begin
            step();
            if (frame_tick !== 1'b0) early = 1'b1;
        end
        step();
        n_run++;
        if (early || frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_first_tick: early=%b tick=%b want early=0 tick=1",
                     early, frame_tick);
        end
        // Discarded load: the first tick counts 0 -> 1 instead of applying 555555.
        exp_q.push_back(ref_word(24'h000001, 0)); name_q.push_back("rst_load_discarded");
        step();
        exp_w = exp_q.pop_front(); exp_n = name_q.pop_front();
        n_run++;
        if (segments !== exp_w) begin
            n_fail++; $display("FAIL %s: got %h want %h", exp_n, segments, exp_w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_static();
        test_back_to_back();
        test_scroll();
        test_count();
        test_blink_overrides();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
